mac_neuron_pipe: RTL
====================

Name: mac_neuron_pipe

Overview:
Pipelined signed fixed-point multiply-accumulate neuron for the 24-bit datapath.
- Consumes a stream of (x, w) pairs, accumulates N_INPUTS products plus a bias, saturates the result to BITSIZE bits, and emits one result per group.
- Fixed latency of 4 cycles, so the downstream fixed-delay alignment stages can match it exactly.
- Sits directly upstream of the activation/delay stages in each layer.

Parameters:
BITSIZE, 24, width of x, w, bias and result (two's complement).
FRAC, 16, fractional bits of all operands (Q(BITSIZE-FRAC).FRAC).
N_INPUTS, 4, products per group; legal range 1..128.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  x/w (and bias on first element) valid this cycle.
in_x  in  BITSIZE  signed input activation.
in_w  in  BITSIZE  signed weight.
in_bias  in  BITSIZE  signed bias; sampled only with the first element of a group.
out_valid  out  1  one-cycle pulse when out_data holds a new result.
out_data  out  BITSIZE  saturated signed neuron sum.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high at a clk edge:
  - out_valid=0 and out_data=0.
  - All internal stage valids=0, element counter=0, accumulator=0.
- Element counter cnt (0..N_INPUTS-1):
  - Increments on each edge where in_valid=1 and wraps to 0 after N_INPUTS-1.
  - first = (cnt==0); last = (cnt==N_INPUTS-1). With N_INPUTS=1, every element is both first and last.
- Pipeline (E = edge sampling an element with in_valid=1):
  - S1 @E: p = signed in_x * in_w (2*BITSIZE bits), registered with valid, first, last and in_bias.
  - S2 @E+1: t = (p + 2^(FRAC-1)) >>> FRAC. This is arithmetic shift, rounding half toward +inf. t is sign-extended to ACC_W = 2*BITSIZE-FRAC+8 bits. valid, first, last and bias are forwarded.
  - S3 @E+2:
    - If first: acc = sext(bias<<0) + t.
    - Else: acc = acc + t.
    - acc never wraps for N_INPUTS ≤ 128.
  - S4 @E+3, only if the element is last: out_data = sat(acc), out_valid=1. Otherwise out_valid=0 and out_data holds its previous value.
- Latency: out_valid is high in the cycle after edge L+3, where L is the edge that sampled the group's last element. It is high for exactly 1 cycle per group.
- Saturation: acc > 2^(BITSIZE-1)-1 gives 0x7FFFFF; acc < -2^(BITSIZE-1) gives 0x800000; otherwise acc is truncated to BITSIZE bits.
- Bubbles: in_valid may drop for any number of cycles mid-group. Stage valids carry the bubbles; acc and cnt hold.
- Back-to-back groups: no dead cycle. The first element of group k+1 may follow the last element of group k on the next edge. The S4 output register is separate from acc, so both results are correct.
- No backpressure: the downstream stage always accepts out_valid.
- Reset mid-group: the partial group is discarded with no out_valid. The next in_valid after reset is treated as first.
- Signed arithmetic throughout. 0x800000 * 0x800000 is handled without overflow in S1.

Test Plan:
1. Basic: N_INPUTS=4, in_x=0x010000 (1.0) and in_w=0x008000 (0.5) on 4 consecutive cycles, in_bias=0x004000 (0.25) -> a single out_valid pulse with out_data=0x024000 (2.25), exactly 4 edges after the 4th sample edge.
2. Rounding: in_x=0x000001 with in_w=0x008000 -> t=1 per element, bias 0 -> out_data=0x000004. Repeat with in_w=0x007FFF -> t=0 per element -> out_data=0x000000.
3. Saturation: in_x=in_w=0x7FFFFF ×4 -> 0x7FFFFF. in_x=0x7FFFFF, in_w=0x800001 ×4 -> 0x800000. in_x=in_w=0x800000 ×4 -> 0x7FFFFF.
4. Back-to-back: 8 continuous valid cycles carrying two groups, with group B using in_w=0xFF8000 (-0.5) and bias 0 -> out_data=0x024000 then 0xFE0000 (-2.0). The two out_valid pulses are exactly 4 cycles apart.
5. Bubbles: test 1 stimulus with 3 idle cycles between elements 2 and 3 -> identical 0x024000, out_valid 4 edges after the last sample; out_valid is never asserted early.
6. Reset mid-group: 2 elements, then rst high for 1 cycle, then a full test 1 group -> no pulse for the partial group, then exactly one pulse with 0x024000.

Source files
------------

// File: rtl/mac_neuron_pipe.sv
// Pipelined signed fixed-point multiply-accumulate neuron. It sums N_INPUTS
// rounded products plus a bias and emits one saturated result per group.
module mac_neuron_pipe #(
  parameter int BITSIZE  = 24,
  parameter int FRAC     = 16,
  parameter int N_INPUTS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [BITSIZE-1:0] in_x,
  input  logic [BITSIZE-1:0] in_w,
  input  logic [BITSIZE-1:0] in_bias,
  output logic               out_valid,
  output logic [BITSIZE-1:0] out_data
);

  // Handshake: an element is consumed on every rising edge where in_valid=1.
  // There is no ready, and out_valid is a one-cycle pulse that is always taken.

  localparam int PW    = 2 * BITSIZE;
  localparam int TW    = PW - FRAC;
  localparam int ACC_W = TW + 8;
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_INPUTS - 1);
  localparam logic signed [PW-1:0]    RND      = PW'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  =
    {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  =
    {{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  // Element counter
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_c, last_c;

  // Stage 1: product
  logic                      s1_valid_q, s1_first_q, s1_last_q;
  logic signed [PW-1:0]      s1_p_q;
  logic        [BITSIZE-1:0] s1_bias_q;

  // Stage 2: rounded, rescaled term
  logic                      s2_valid_q, s2_first_q, s2_last_q;
  logic signed [ACC_W-1:0]   s2_t_q;
  logic        [BITSIZE-1:0] s2_bias_q;

  // Stage 3: accumulator
  logic                      s3_valid_q, s3_last_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  // Stage 4: output register
  logic                      out_valid_q;
  logic        [BITSIZE-1:0] out_data_q, out_data_d;

  logic signed [PW-1:0]      prod_c;
  logic signed [PW-1:0]      rnd_c;
  logic signed [ACC_W-1:0]   t_c;
  logic signed [ACC_W-1:0]   bias_ext_c;

  assign first_c = (cnt_q == '0);
  assign last_c  = (cnt_q == CNT_LAST);
  assign cnt_d   = last_c ? '0 : cnt_q + CNT_W'(1);

  // Both operands are sign-extended to full width so 0x800000^2 cannot overflow.
  assign prod_c = $signed({{BITSIZE{in_x[BITSIZE-1]}}, in_x}) *
                  $signed({{BITSIZE{in_w[BITSIZE-1]}}, in_w});

  // Taking the top TW bits of the rounded product is the arithmetic shift by FRAC.
  assign rnd_c      = s1_p_q + RND;
  assign t_c        = {{8{rnd_c[PW-1]}}, rnd_c[PW-1:FRAC]};
  assign bias_ext_c = {{(ACC_W-BITSIZE){s2_bias_q[BITSIZE-1]}}, s2_bias_q};

  always_comb begin
    acc_d = acc_q;
    if (s2_valid_q) begin
      acc_d = s2_first_q ? (bias_ext_c + s2_t_q) : (acc_q + s2_t_q);
    end
  end

  always_comb begin
    out_data_d = acc_q[BITSIZE-1:0];
    if (acc_q > SAT_MAX) begin
      out_data_d = SAT_MAX[BITSIZE-1:0];
    end else if (acc_q < SAT_MIN) begin
      out_data_d = SAT_MIN[BITSIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_p_q      <= '0;
      s1_bias_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_t_q      <= '0;
      s2_bias_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (in_valid) begin
        cnt_q <= cnt_d;
      end

      s1_valid_q <= in_valid;
      s1_first_q <= first_c;
      s1_last_q  <= last_c;
      s1_p_q     <= prod_c;
      s1_bias_q  <= in_bias;

      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_t_q     <= t_c;
      s2_bias_q  <= s1_bias_q;

      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      acc_q      <= acc_d;

      // acc_q still holds the finished group even if the next group starts now.
      out_valid_q <= s3_valid_q && s3_last_q;
      if (s3_valid_q && s3_last_q) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
